saes_round_ctrl: RTL and testbench
==================================

SAES_ROUND_CTRL -- requirements
Module: saes_round_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 1: cycles per datapath step, legal range 1..15.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  in  1  block-request valid.
REQ-005 SHALL have port in_ready  out  1  controller can accept a request.
REQ-006 SHALL have port decrypt  in  1  mode, sampled on accept: 0 = encrypt, 1 = decrypt.
REQ-007 SHALL have port out_valid  out  1  datapath result ready.
REQ-008 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-009 SHALL have port dp_load  out  1  datapath loads the input block into its state register.
REQ-010 SHALL have port dp_en  out  1  datapath executes dp_op this cycle.
REQ-011 SHALL have port dp_op  out  3  operation: 0 NOP, 1 ARK, 2 SUB, 3 SHR, 4 MIX, 5 ISUB, 6 IMIX.
REQ-012 SHALL have port key_sel  out  2  round-key index (0 = K0, 1 = K1, 2 = K2) for ARK.
REQ-013 SHALL have port round  out  2  current round number (0..2).
REQ-014 SHALL have port busy  out  1  request in progress (LOAD, STEP or DONE state).

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, STEP and DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; accept = in_valid & in_ready; on accept, SHALL latch decrypt and go to LOAD.
REQ-017 SHALL, in LOAD, assert dp_load for exactly 1 cycle, then go to STEP with step index = 0.
REQ-018 SHALL, in STEP, run 8 steps; each step lasts LAT cycles, dp_en = 1 only in the first cycle of the step, and a wait counter counts the remaining LAT-1 cycles.
REQ-019 SHALL use this encrypt sequence (op/key_sel): ARK/0, SUB, SHR, MIX, ARK/1, SUB, SHR, ARK/2.
REQ-020 SHALL use this decrypt sequence: ARK/2, SHR, ISUB, ARK/1, IMIX, SHR, ISUB, ARK/0; SHR serves as its own inverse, since a nibble-row swap is self-inverse.
REQ-021 SHALL drive round = 0 for step 0, 1 for steps 1-4 and 2 for steps 5-7, in both modes.
REQ-022 SHALL hold dp_op and key_sel stable for the whole step; outside STEP, dp_op = 0 and key_sel = 0.
REQ-023 SHALL drive key_sel = 0 during non-ARK steps.
REQ-024 SHALL go to DONE after the last cycle of step 7.
REQ-025 SHALL, in DONE, assert out_valid and hold it until out_ready = 1; dp_en = 0 throughout DONE.
REQ-026 SHALL, on out_valid & out_ready, go to IDLE on the next edge; in_ready is first asserted the cycle after the handshake (no same-cycle turnaround).
REQ-027 SHALL, with LAT = 1, give latency of accept at cycle 0, dp_load at cycle 1, steps at cycles 2-9, out_valid from cycle 10.
REQ-028 SHALL give general latency of accept to out_valid = 2 + 8*LAT cycles.
REQ-029 SHALL ignore in_valid and decrypt outside IDLE.
REQ-030 SHALL ignore out_ready outside DONE.
REQ-031 SHALL ensure that a change of decrypt after accept does not alter the sequence in progress.
REQ-032 SHALL drive all outputs from registers or decode of registered state only; no combinational path from in_valid or out_ready to any output other than none.
REQ-033 SHALL keep the step index 3 bits wide; step index 7 is terminal, with no wrap into step 0 without a new LOAD.

Reset
REQ-034 SHALL, while rst = 1, immediately (without a clock) force state IDLE, step = 0, wait counter = 0 and the latched mode = 0.
REQ-035 SHALL force these reset output values: in_ready = 1, out_valid = 0, dp_load = 0, dp_en = 0, dp_op = 0, key_sel = 0, round = 0, busy = 0.
REQ-036 SHALL, on rst asserted mid-operation (any state), abandon the operation with no out_valid; the first accept after rst deasserts starts a fresh sequence.

Verification
REQ-037 SHALL pass this test: LAT=1, encrypt accept at cycle 0 -> dp_load@1; dp_en@2..9 with ops 1,2,3,4,1,2,3,1 and key_sel 0,x,x,x,1,x,x,2; round 0,1,1,1,1,2,2,2; out_valid@10.
REQ-038 SHALL pass this test: LAT=1, decrypt -> ops 1,3,5,1,6,3,5,1 and key_sel 2,-,-,1,-,-,-,0; out_valid@10.
REQ-039 SHALL pass this test: LAT=3, encrypt -> dp_en pulses at cycles 2,5,...,23 only; out_valid@26; dp_op held for 3 cycles per step.
REQ-040 SHALL pass this test: out_ready held 0 for 5 cycles after out_valid -> out_valid stays 1 with no dp_en; on out_ready = 1, IDLE next cycle; a back-to-back in_valid is accepted one cycle after the handshake.
REQ-041 SHALL pass this test: rst pulsed during step 4 -> all outputs at reset values immediately with no out_valid; a new request then completes normally.
REQ-042 SHALL pass this test: in_valid and decrypt toggled during STEP -> no effect on the op sequence and in_ready stays 0.

Source files
------------

// File: rtl/saes_round_ctrl.sv
// Round sequencer for a small nibble-oriented AES-like datapath.
// It issues load, round-step and key-select controls for one block per request.
module saes_round_ctrl #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       decrypt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       dp_load,
    output logic       dp_en,
    output logic [2:0] dp_op,
    output logic [1:0] key_sel,
    output logic [1:0] round,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ARK  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_MIX  = 3'd4;
    localparam logic [2:0] OP_ISUB = 3'd5;
    localparam logic [2:0] OP_IMIX = 3'd6;

    localparam logic [2:0] LAST_STEP = 3'd7;
    localparam logic [3:0] WAIT_LAST = 4'(LAT - 1);

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [3:0] wait_q, wait_d;
    logic       mode_q, mode_d;

    logic [2:0] seq_op;
    logic [1:0] seq_key;
    logic [1:0] seq_round;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
            wait_q  <= 4'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            wait_q  <= wait_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        wait_d  = wait_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d  = decrypt;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                step_d  = 3'd0;
                wait_d  = 4'd0;
                state_d = S_STEP;
            end
            S_STEP: begin
                // A step ends once the wait counter has covered its LAT-1 idle cycles.
                if (wait_q == WAIT_LAST) begin
                    wait_d = 4'd0;
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    step_d  = 3'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Step tables; decryption walks the rounds backwards with inverse ops.
    always_comb begin
        seq_op  = OP_NOP;
        seq_key = 2'd0;
        if (!mode_q) begin
            case (step_q)
                3'd0: begin seq_op = OP_ARK; seq_key = 2'd0; end
                3'd1: seq_op = OP_SUB;
                3'd2: seq_op = OP_SHR;
                3'd3: seq_op = OP_MIX;
                3'd4: begin seq_op = OP_ARK; seq_key = 2'd1; end
                3'd5: seq_op = OP_SUB;
                3'd6: seq_op = OP_SHR;
                default: begin seq_op = OP_ARK; seq_key = 2'd2; end
            endcase
        end else begin
            case (step_q)
                3'd0: begin seq_op = OP_ARK; seq_key = 2'd2; end
                3'd1: seq_op = OP_SHR;
                3'd2: seq_op = OP_ISUB;
                3'd3: begin seq_op = OP_ARK; seq_key = 2'd1; end
                3'd4: seq_op = OP_IMIX;
                3'd5: seq_op = OP_SHR;
                3'd6: seq_op = OP_ISUB;
                default: begin seq_op = OP_ARK; seq_key = 2'd0; end
            endcase
        end
    end

    always_comb begin
        if (step_q == 3'd0) begin
            seq_round = 2'd0;
        end else if (step_q <= 3'd4) begin
            seq_round = 2'd1;
        end else begin
            seq_round = 2'd2;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        dp_load   = (state_q == S_LOAD);
        out_valid = (state_q == S_DONE);
        dp_en     = 1'b0;
        dp_op     = OP_NOP;
        key_sel   = 2'd0;
        round     = 2'd0;
        if (state_q == S_STEP) begin
            dp_en   = (wait_q == 4'd0);
            dp_op   = seq_op;
            key_sel = seq_key;
            round   = seq_round;
        end
    end

endmodule

// File: tb/tb_saes_round_ctrl.sv
// Self-checking bench for saes_round_ctrl: LAT=1 and LAT=3 instances share stimulus,
// expected step controls are queued on accept and popped on each dp_en pulse.
module tb_saes_round_ctrl;

    typedef struct {
        logic [2:0] op;
        logic [1:0] ks;
        logic [1:0] rnd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic decrypt = 1'b0;
    logic out_ready = 1'b1;

    logic       in_ready_a, out_valid_a, dp_load_a, dp_en_a, busy_a;
    logic [2:0] dp_op_a;
    logic [1:0] key_sel_a, round_a;
    logic       in_ready_b, out_valid_b, dp_load_b, dp_en_b, busy_b;
    logic [2:0] dp_op_b;
    logic [1:0] key_sel_b, round_b;

    logic       sel_b = 1'b0;
    logic       obs_in_ready, obs_out_valid, obs_dp_load, obs_dp_en, obs_busy;
    logic [2:0] obs_dp_op;
    logic [1:0] obs_key_sel, obs_round;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    localparam logic [11:0] RESET_OUTS = 12'b1000_000_00_00_0;

    always #5 clk = ~clk;

    saes_round_ctrl #(.LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .decrypt(decrypt), .out_valid(out_valid_a), .out_ready(out_ready),
        .dp_load(dp_load_a), .dp_en(dp_en_a), .dp_op(dp_op_a),
        .key_sel(key_sel_a), .round(round_a), .busy(busy_a)
    );

    saes_round_ctrl #(.LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .decrypt(decrypt), .out_valid(out_valid_b), .out_ready(out_ready),
        .dp_load(dp_load_b), .dp_en(dp_en_b), .dp_op(dp_op_b),
        .key_sel(key_sel_b), .round(round_b), .busy(busy_b)
    );

    assign obs_in_ready  = sel_b ? in_ready_b  : in_ready_a;
    assign obs_out_valid = sel_b ? out_valid_b : out_valid_a;
    assign obs_dp_load   = sel_b ? dp_load_b   : dp_load_a;
    assign obs_dp_en     = sel_b ? dp_en_b     : dp_en_a;
    assign obs_busy      = sel_b ? busy_b      : busy_a;
    assign obs_dp_op     = sel_b ? dp_op_b     : dp_op_a;
    assign obs_key_sel   = sel_b ? key_sel_b   : key_sel_a;
    assign obs_round     = sel_b ? round_b     : round_a;

    task automatic push_expected(input bit dec);
        int   eo[8];
        int   ek[8];
        int   dop[8];
        int   dk[8];
        int   rn[8];
        exp_t e;
        eo  = '{1, 2, 3, 4, 1, 2, 3, 1};
        ek  = '{0, 0, 0, 0, 1, 0, 0, 2};
        dop = '{1, 3, 5, 1, 6, 3, 5, 1};
        dk  = '{2, 0, 0, 1, 0, 0, 0, 0};
        rn  = '{0, 1, 1, 1, 1, 2, 2, 2};
        for (int i = 0; i < 8; i++) begin
            e.op  = dec ? 3'(dop[i]) : 3'(eo[i]);
            e.ks  = dec ? 2'(dk[i])  : 2'(ek[i]);
            e.rnd = 2'(rn[i]);
            sb_q.push_back(e);
        end
    endtask

    // Accepts one request on the selected instance and follows it up to out_valid.
    task automatic run_txn(input bit dec, input bit use_b, input int lat, input bit toggle);
        exp_t cur;
        bit   exp_en;
        int   waited;
        sel_b  = use_b;
        waited = 0;
        cur.op = 3'd0; cur.ks = 2'd0; cur.rnd = 2'd0;
        while (obs_in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (obs_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1", obs_in_ready);
        end
        in_valid = 1'b1;
        decrypt  = dec;
        push_expected(dec);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (obs_dp_load !== 1'b1 || obs_busy !== 1'b1 || obs_dp_en !== 1'b0) begin
            n_fail++;
            $display("FAIL load_cycle: dp_load=%b busy=%b dp_en=%b required 1 1 0",
                     obs_dp_load, obs_busy, obs_dp_en);
        end
        for (int c = 2; c < 2 + 8 * lat; c++) begin
            @(negedge clk);
            if (toggle) begin
                in_valid = 1'($urandom);
                decrypt  = 1'($urandom);
            end
            exp_en = ((c - 2) % lat) == 0;
            n_checks++;
            if (obs_dp_en !== exp_en || obs_in_ready !== 1'b0 || obs_dp_load !== 1'b0) begin
                n_fail++;
                $display("FAIL step_ctrl cycle %0d: dp_en=%b in_ready=%b dp_load=%b required %b 0 0",
                         c, obs_dp_en, obs_in_ready, obs_dp_load, exp_en);
            end
            if (exp_en) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow cycle %0d: dp_en with no expected step", c);
                end else begin
                    cur = sb_q.pop_front();
                    n_checks++;
                    if (obs_dp_op !== cur.op || obs_key_sel !== cur.ks || obs_round !== cur.rnd) begin
                        n_fail++;
                        $display("FAIL step_op cycle %0d: op=%0d key=%0d round=%0d required %0d %0d %0d",
                                 c, obs_dp_op, obs_key_sel, obs_round, cur.op, cur.ks, cur.rnd);
                    end
                end
            end else begin
                n_checks++;
                if (obs_dp_op !== cur.op || obs_key_sel !== cur.ks) begin
                    n_fail++;
                    $display("FAIL op_hold cycle %0d: op=%0d key=%0d required %0d %0d",
                             c, obs_dp_op, obs_key_sel, cur.op, cur.ks);
                end
            end
        end
        in_valid = 1'b0;
        decrypt  = dec;
        @(negedge clk);
        n_checks++;
        if (obs_out_valid !== 1'b1 || obs_dp_en !== 1'b0 || obs_busy !== 1'b1 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_cycle %0d: out_valid=%b dp_en=%b busy=%b pending=%0d required 1 0 1 0",
                     2 + 8 * lat, obs_out_valid, obs_dp_en, obs_busy, sb_q.size());
        end
        $display("txn dec=%0b lat=%0d toggle=%0b done", dec, lat, toggle);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready_a, out_valid_a, dp_load_a, dp_en_a, dp_op_a, key_sel_a, round_a, busy_a} !== RESET_OUTS ||
            {in_ready_b, out_valid_b, dp_load_b, dp_en_b, dp_op_b, key_sel_b, round_b, busy_b} !== RESET_OUTS) begin
            n_fail++;
            $display("FAIL reset_outputs: a=%b b=%b required %b",
                     {in_ready_a, out_valid_a, dp_load_a, dp_en_a, dp_op_a, key_sel_a, round_a, busy_a},
                     {in_ready_b, out_valid_b, dp_load_b, dp_en_b, dp_op_b, key_sel_b, round_b, busy_b},
                     RESET_OUTS);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic check_idle_after(input string name);
        @(negedge clk);
        n_checks++;
        if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     name, obs_in_ready, obs_out_valid, obs_busy);
        end
    endtask

    task automatic test_encrypt_lat1();
        out_ready = 1'b1;
        run_txn(1'b0, 1'b0, 1, 1'b0);
        check_idle_after("enc1");
    endtask

    task automatic test_decrypt_lat1();
        out_ready = 1'b1;
        run_txn(1'b1, 1'b0, 1, 1'b0);
        check_idle_after("dec1");
    endtask

    task automatic test_lat3();
        out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_txn(1'b0, 1'b1, 3, 1'b0);
        check_idle_after("lat3");
        sel_b = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        run_txn(1'b1, 1'b0, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_out_valid !== 1'b1 || obs_dp_en !== 1'b0 || obs_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL done_hold %0d: out_valid=%b dp_en=%b in_ready=%b required 1 0 0",
                         i, obs_out_valid, obs_dp_en, obs_in_ready);
            end
        end
        out_ready = 1'b1;
        n_checks++;
        if (obs_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL no_turnaround: in_ready=%b required 0", obs_in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake_idle: in_ready=%b out_valid=%b required 1 0", obs_in_ready, obs_out_valid);
        end
        run_txn(1'b0, 1'b0, 1, 1'b0);
        check_idle_after("b2b");
    endtask

    task automatic test_rst_midop();
        int waited;
        sel_b     = 1'b0;
        out_ready = 1'b1;
        waited    = 0;
        while (in_ready_a !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b1;
        decrypt  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (dp_en_a !== 1'b1 || dp_op_a !== 3'd1 || key_sel_a !== 2'd1) begin
            n_fail++;
            $display("FAIL midop_step4: dp_en=%b op=%0d key=%0d required 1 1 1", dp_en_a, dp_op_a, key_sel_a);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready_a, out_valid_a, dp_load_a, dp_en_a, dp_op_a, key_sel_a, round_a, busy_a} !== RESET_OUTS) begin
            n_fail++;
            $display("FAIL async_reset: outs=%b required %b",
                     {in_ready_a, out_valid_a, dp_load_a, dp_en_a, dp_op_a, key_sel_a, round_a, busy_a}, RESET_OUTS);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
                n_fail++;
                $display("FAIL abandoned %0d: out_valid=%b in_ready=%b required 0 1", i, out_valid_a, in_ready_a);
            end
        end
        sb_q.delete();
        run_txn(1'b1, 1'b0, 1, 1'b0);
        check_idle_after("post_rst");
    endtask

    task automatic test_toggle_inputs();
        out_ready = 1'b1;
        run_txn(1'b0, 1'b0, 1, 1'b1);
        check_idle_after("toggle");
    endtask

    initial begin
        test_reset();
        test_encrypt_lat1();
        test_decrypt_lat1();
        test_lat3();
        test_back_to_back();
        test_rst_midop();
        test_toggle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
